// File: rtl/sub4_seq_ctrl.sv
// Nibble-serial subtractor sequencer: computes op_a - op_b - bin by sharing one external
// 4-bit borrow subtractor, one nibble per clock, LSB first.
//
// Handshake: a start seen in IDLE or DONE is accepted on that clock edge (operands latched);
// start seen while RUN is ignored. done is a single-cycle pulse; diff/bout/zero hold
// from that point until the next accepted start.
module sub4_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic [3:0]       sub_x,
  output logic [3:0]       sub_y,
  output logic             sub_z,
  input  logic             sub_b,
  input  logic [3:0]       sub_d
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             borrow;
  logic [WIDTH-1:0] diff_nxt;
  logic             accept;
  logic             last;

  assign accept = start && (state != S_RUN);
  assign last   = (idx == IW'(NIBBLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Subtractor operands come only from registers, never from start/op_* directly.
  assign sub_x = a_q[4*idx +: 4];
  assign sub_y = b_q[4*idx +: 4];
  assign sub_z = borrow;

  always_comb begin
    diff_nxt             = diff;
    diff_nxt[4*idx +: 4] = sub_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b1;
    end else if (accept) begin
      a_q    <= op_a;
      b_q    <= op_b;
      borrow <= bin;
      idx    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b1;
    end else if (state == S_RUN) begin
      diff   <= diff_nxt;
      borrow <= sub_b;
      // idx parks on the last nibble so sub_x/sub_y hold their final value outside RUN.
      if (!last) begin
        idx <= idx + IW'(1);
      end else begin
        bout <= sub_b;
        zero <= (diff_nxt == '0);
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_sub4_seq_ctrl.sv
// Directed and random checks of sub4_seq_ctrl at WIDTH=16, with a behavioural 4-bit
// borrow subtractor standing in for the external substractor_4.
module tb_sub4_seq_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic [3:0]   sub_x;
  logic [3:0]   sub_y;
  logic         sub_z;
  logic         sub_b;
  logic [3:0]   sub_d;

  int vectors;
  int miscompares;

  sub4_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .sub_x (sub_x),
    .sub_y (sub_y),
    .sub_z (sub_z),
    .sub_b (sub_b),
    .sub_d (sub_d)
  );

  // External subtractor: x - y - z, bit 4 of the 5-bit result is borrow-out.
  logic [4:0] sub_res;
  assign sub_res = {1'b0, sub_x} - {1'b0, sub_y} - {4'b0, sub_z};
  assign sub_b   = sub_res[4];
  assign sub_d   = sub_res[3:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at #1 after an edge with the DUT in IDLE or DONE; returns at #1 after EN+1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W-1:0] ed, input logic eb, input logic ez,
                        input string name);
    op_a = a; op_b = b; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); bin = 1'($urandom);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy@E0: busy=%b done=%b want busy=1 done=0", name, busy, done);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy@E3: busy=%b done=%b want busy=1 done=0", name, busy, done);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done@E4: done=%b busy=%b want done=1 busy=0", name, done, busy);
    end
    vectors++;
    if (diff !== ed || bout !== eb || zero !== ez) begin
      miscompares++;
      $display("FAIL %s result: diff=%h bout=%b zero=%b want diff=%h bout=%b zero=%b",
               name, diff, bout, zero, ed, eb, ez);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== ed || bout !== eb) begin
      miscompares++;
      $display("FAIL %s hold@E5: done=%b busy=%b diff=%h bout=%b want done=0 busy=0 diff=%h bout=%b",
               name, done, busy, diff, bout, ed, eb);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0000 || bout !== 1'b0 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL reset outputs: busy=%b done=%b diff=%h bout=%b zero=%b want 0 0 0000 0 1",
               busy, done, diff, bout, zero);
    end
    vectors++;
    if (sub_x !== 4'h0 || sub_y !== 4'h0 || sub_z !== 1'b0) begin
      miscompares++;
      $display("FAIL reset sub_ops: x=%h y=%h z=%b want 0 0 0", sub_x, sub_y, sub_z);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, "v1");
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "v2_ripple");
    run_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, "v3_bin1");
    run_op(16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, "v3_bin0");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "ffff_bin1");
    run_op(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, "ffff_minus0");
  endtask

  task automatic test_back_to_back();
    op_a = 16'h1234; op_b = 16'h0234; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    @(posedge clk); #1;                       // E1
    @(posedge clk); #1;                       // E2
    op_a = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;                       // E3: start ignored
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b ignore: busy=%b done=%b want busy=1 done=0", busy, done);
    end
    @(posedge clk); #1;                       // E4
    vectors++;
    if (done !== 1'b1 || diff !== 16'h1000 || bout !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b first: done=%b diff=%h bout=%b zero=%b want 1 1000 0 0",
               done, diff, bout, zero);
    end
    op_a = 16'h0000; op_b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // E5: accepted from DONE
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || diff !== 16'h0000 || bout !== 1'b0 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b accept: busy=%b done=%b diff=%h bout=%b zero=%b want 1 0 0000 0 1",
               busy, done, diff, bout, zero);
    end
    repeat (3) @(posedge clk);
    @(posedge clk); #1;                       // E9
    vectors++;
    if (done !== 1'b1 || diff !== 16'hFFFF || bout !== 1'b1 || zero !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b second: done=%b diff=%h bout=%b zero=%b want 1 ffff 1 0",
               done, diff, bout, zero);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b idle: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid();
    op_a = 16'h8000; op_b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    @(posedge clk); #1;                       // E1
    @(posedge clk); #1;                       // E2
    vectors++;
    if (diff !== 16'h00FF || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid partial: diff=%h busy=%b want 00ff 1", diff, busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0000 || bout !== 1'b0 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid clear: busy=%b done=%b diff=%h bout=%b zero=%b want 0 0 0000 0 1",
               busy, done, diff, bout, zero);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || sub_x !== 4'h0 || sub_z !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid hold: done=%b busy=%b x=%h z=%b want 0 0 0 0", done, busy, sub_x, sub_z);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, "rstmid_restart");
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W:0]   ref_v;
    for (int i = 0; i < 1000; i++) begin
      a  = W'($urandom_range(0, 16'hFFFF));
      b  = (i % 8 == 0) ? a : W'($urandom_range(0, 16'hFFFF));
      bi = 1'($urandom_range(0, 1));
      ref_v = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
      run_op(a, b, bi, ref_v[W-1:0], ref_v[W], (ref_v[W-1:0] == '0), "rand");
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
